// File: rtl/mul16_seq_if.sv
// Start/operand request and status/product response bundle for mul16_seq.
// Start is taken only while ready; no backpressure on the result, which holds until the next start.
interface mul16_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product;

    modport master (
        output start, a, b,
        input  ready, busy, done, product
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, product
    );
endinterface

// File: rtl/mul16_seq.sv
// Shift-and-add 16x16 -> low-16 multiplier around one Add16; done pulses 16 cycles after the start edge.
// Start is accepted only in IDLE (ready=1) and is dropped, not queued, while RUN or DONE.
module mul16_seq #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    mul16_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [4:0]       count;
    logic [WIDTH-1:0] sum;

    Add16 u_add (
        .a   (acc),
        .b   (mcand),
        .sum (sum)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (count == 5'd15) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Fixed 16 iterations: no early exit even when the multiplier runs out of ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand  <= bus.a;
                        mplier <= bus.b;
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                RUN: begin
                    acc    <= mplier[0] ? sum : acc;
                    mcand  <= {mcand[WIDTH-2:0], 1'b0};
                    mplier <= {1'b0, mplier[WIDTH-1:1]};
                    count  <= count + 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready   = (state == IDLE);
    assign bus.busy    = (state == RUN);
    assign bus.done    = (state == DONE);
    assign bus.product = acc;
endmodule

// Plain 16-bit adder, carry out of bit 15 dropped.
module Add16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum
);
    assign sum = a + b;
endmodule

// File: tb/tb_mul16_seq.sv
// Directed and random checks of mul16_seq against a transaction-level model of accept/run/done timing.
module tb_mul16_seq;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    int   cyc;
    int   ph;
    logic [15:0] m_res;
    logic [15:0] m_prod;
    bit   b2b;
    int   last_done;
    int   n_b2b_done;

    mul16_seq_if bus ();

    mul16_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        ph     = 0;
        m_prod = 16'h0000;
    endtask

    // ph: 0 idle, 1..16 running cycles, 17 the done cycle.
    task automatic model_edge();
        if (reset) return;
        if (ph == 0) begin
            if (bus.start) begin
                ph     = 1;
                m_res  = bus.a * bus.b;
                m_prod = 16'h0000;
            end
        end else if (ph < 16) begin
            ph++;
        end else if (ph == 16) begin
            ph     = 17;
            m_prod = m_res;
        end else begin
            ph = 0;
        end
    endtask

    task automatic check_outputs();
        chk("ready", {15'd0, bus.ready}, {15'd0, ph == 0});
        chk("busy",  {15'd0, bus.busy},  {15'd0, ph >= 1 && ph <= 16});
        chk("done",  {15'd0, bus.done},  {15'd0, ph == 17});
        if (ph == 0 || ph == 17) chk("product", bus.product, m_prod);
        if (b2b && bus.done === 1'b1) begin
            if (last_done >= 0) chk("b2b_gap", 16'(cyc - last_done), 16'd18);
            last_done = cyc;
            n_b2b_done++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic run_op(input logic [15:0] aa, input logic [15:0] bb, input logic [15:0] exp);
        bus.a = aa;
        bus.b = bb;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.a = 16'($urandom);
        bus.b = 16'($urandom);
        repeat (16) step();
        chk("op_done", {15'd0, bus.done}, 16'd1);
        chk("op_prod", bus.product, exp);
        step();
        chk("op_ready", {15'd0, bus.ready}, 16'd1);
        chk("op_hold", bus.product, exp);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc = 0;
        b2b = 1'b0;
        last_done = -1;
        n_b2b_done = 0;
        m_res = 16'h0000;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.a = 16'h0000;
        bus.b = 16'h0000;
        model_reset();
        #2;
        check_outputs();
        step();
        step();
        reset = 1'b0;

        run_op(16'h0003, 16'h0005, 16'h000F);
        run_op(16'hFFFF, 16'hFFFF, 16'h0001);
        run_op(16'h0100, 16'h0100, 16'h0000);
        run_op(16'hFFFD, 16'h0007, 16'hFFEB);
        run_op(16'h1234, 16'h0000, 16'h0000);

        // Starts during RUN and on the DONE-entry edge must be dropped.
        bus.a = 16'h0003; bus.b = 16'h0005; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (3) step();
        bus.a = 16'h0009; bus.b = 16'h0009; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (11) step();
        bus.a = 16'h0009; bus.b = 16'h0009; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("ign_done", {15'd0, bus.done}, 16'd1);
        chk("ign_prod", bus.product, 16'h000F);
        step();
        chk("ign_idle_prod", bus.product, 16'h000F);
        run_op(16'h0009, 16'h0009, 16'h0051);

        // Asynchronous abort mid-run.
        bus.a = 16'h0007; bus.b = 16'h0007; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (8) step();
        #2 reset = 1'b1;
        #1;
        chk("abort_ready", {15'd0, bus.ready}, 16'd1);
        chk("abort_busy",  {15'd0, bus.busy},  16'd0);
        chk("abort_done",  {15'd0, bus.done},  16'd0);
        chk("abort_prod",  bus.product,       16'h0000);
        model_reset();
        #1 reset = 1'b0;
        repeat (20) step();
        run_op(16'h0002, 16'h0002, 16'h0004);

        for (int i = 0; i < 12; i++) begin
            logic [15:0] x;
            logic [15:0] y;
            logic [15:0] p;
            x = 16'($urandom);
            y = 16'($urandom);
            if (i < 3) y = 16'($urandom_range(0, 3));
            p = x * y;
            run_op(x, y, p);
        end

        // Start held high with fresh operands every cycle.
        b2b = 1'b1;
        bus.start = 1'b1;
        for (int i = 0; i < 70; i++) begin
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
            step();
        end
        bus.start = 1'b0;
        repeat (20) step();
        b2b = 1'b0;
        chk("b2b_count", 16'(n_b2b_done), 16'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
